// File: rtl/o_serdes_tx_framer_pkg.sv
// Shared types and constants for the serializer transmit framer.
package o_serdes_pkg;

   typedef enum logic [1:0] {
      OFF   = 2'd0,
      TRAIN = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } tx_state_t;

   localparam int WIDTH_MIN = 3;
   localparam int WIDTH_MAX = 10;

   // Alternating 1/0 starting at bit width-1, right-aligned in WIDTH_MAX bits.
   function automatic logic [WIDTH_MAX-1:0] default_train_pattern(input int unsigned width);
      logic [WIDTH_MAX-1:0] pat;
      pat = '0;
      for (int unsigned i = 0; i < WIDTH_MAX; i++) begin
         if (i < width) pat[width-1-i] = ~i[0];
      end
      return pat;
   endfunction

endpackage

// File: rtl/o_serdes_tx_framer_fifo.sv
// Synchronous word FIFO with flush; written words become readable one cycle after the write.
module tx_word_fifo #(
   parameter int W     = 5,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty,
   output logic         readable
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic [AW:0]  wr_ptr_vis;

   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty    = (wr_ptr == rd_ptr);
   // Reads see the write pointer one cycle late, giving the FIFO stage its cycle of latency.
   assign readable = (wr_ptr_vis != rd_ptr);
   assign rdata    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         wr_ptr_vis <= '0;
      end else if (flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         wr_ptr_vis <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + 1'b1;
         if (pop && readable) rd_ptr <= rd_ptr + 1'b1;
         wr_ptr_vis <= wr_ptr;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/o_serdes_tx_framer.sv
// Fabric-side framer feeding the output serializer: training bursts, buffered streaming, drain.
module o_serdes_tx_framer
   import o_serdes_pkg::*;
#(
   parameter int               WIDTH         = 4,
   parameter int               FIFO_DEPTH    = 4,
   parameter logic [WIDTH-1:0] TRAIN_PATTERN = WIDTH'(default_train_pattern(WIDTH)),
   parameter int               TRAIN_WORDS   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             pll_lock,
   input  logic             train_req,
   input  logic [WIDTH-1:0] s_data,
   input  logic             s_oe,
   input  logic             s_valid,
   output logic             s_ready,
   output logic [WIDTH-1:0] d_out,
   output logic             data_valid_out,
   output logic             oe_out,
   output logic [1:0]       state_out,
   output logic             train_done,
   output logic             underrun,
   output logic [15:0]      word_count
);

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
      $fatal(1, "o_serdes_tx_framer: WIDTH %0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $fatal(1, "o_serdes_tx_framer: FIFO_DEPTH %0d must be a power of two >= 2", FIFO_DEPTH);
   end
   if (TRAIN_WORDS < 1 || TRAIN_WORDS > 255) begin : g_bad_train
      $fatal(1, "o_serdes_tx_framer: TRAIN_WORDS %0d outside 1..255", TRAIN_WORDS);
   end

   localparam logic [7:0] TLAST = 8'(TRAIN_WORDS - 1);

   logic [1:0]     sync_q;
   logic           lock_s;
   tx_state_t      state;
   tx_state_t      state_nx;
   logic [7:0]     tcnt;
   logic [7:0]     tcnt_nx;
   logic           fifo_push;
   logic           fifo_pop;
   logic           fifo_flush;
   logic           fifo_full;
   logic           fifo_empty;
   logic           fifo_readable;
   logic [WIDTH:0] fifo_rdata;

   assign lock_s     = sync_q[1];
   assign s_ready    = !fifo_full && (state != DRAIN);
   assign fifo_push  = s_valid && s_ready;
   assign fifo_flush = !lock_s;
   assign fifo_pop   = fifo_readable && (state_nx == RUN || state_nx == DRAIN);
   assign state_out  = state;

   tx_word_fifo #(
      .W     (WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (fifo_push),
      .pop      (fifo_pop),
      .flush    (fifo_flush),
      .wdata    ({s_oe, s_data}),
      .rdata    (fifo_rdata),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .readable (fifo_readable)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) sync_q <= '0;
      else        sync_q <= {sync_q[0], pll_lock};
   end

   always_comb begin
      state_nx = state;
      tcnt_nx  = (state == TRAIN) ? tcnt + 8'd1 : '0;
      if (!lock_s) begin
         state_nx = OFF;
      end else begin
         case (state)
            OFF:     if (enable) state_nx = TRAIN;
            TRAIN:   if (!enable) state_nx = DRAIN;
                     else if (tcnt == TLAST) state_nx = RUN;
            RUN:     if (!enable) state_nx = DRAIN;
                     else if (train_req) state_nx = TRAIN;
            DRAIN:   if (fifo_empty) state_nx = OFF;
            default: state_nx = OFF;
         endcase
      end
   end

   // Outputs are registered from the action of the state being entered, so they line up with state_out.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= OFF;
         tcnt           <= '0;
         d_out          <= '0;
         data_valid_out <= 1'b0;
         oe_out         <= 1'b0;
         train_done     <= 1'b0;
         underrun       <= 1'b0;
         word_count     <= '0;
      end else begin
         state          <= state_nx;
         d_out          <= '0;
         data_valid_out <= 1'b0;
         oe_out         <= 1'b0;
         train_done     <= 1'b0;
         underrun       <= 1'b0;
         case (state_nx)
            TRAIN: begin
               tcnt           <= tcnt_nx;
               train_done     <= (tcnt_nx == TLAST);
               d_out          <= TRAIN_PATTERN;
               data_valid_out <= 1'b1;
               oe_out         <= 1'b1;
            end
            RUN, DRAIN: begin
               if (fifo_readable) begin
                  d_out          <= fifo_rdata[WIDTH-1:0];
                  oe_out         <= fifo_rdata[WIDTH];
                  data_valid_out <= 1'b1;
                  if (state_nx == RUN && word_count != 16'hFFFF) word_count <= word_count + 16'd1;
               end else if (state_nx == RUN) begin
                  underrun <= 1'b1;
               end
            end
            default: ;
         endcase
         if (state == OFF && state_nx == TRAIN) word_count <= '0;
      end
   end

endmodule

// File: tb/tb_o_serdes_tx_framer.sv
// Scoreboard bench for o_serdes_tx_framer: table-driven streams plus hand-written corner sequences.
module tb_o_serdes_tx_framer;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        pll_lock;
   logic        train_req;
   logic [3:0]  s_data;
   logic        s_oe;
   logic        s_valid;
   logic        s_ready;
   logic [3:0]  d_out;
   logic        data_valid_out;
   logic        oe_out;
   logic [1:0]  state_out;
   logic        train_done;
   logic        underrun;
   logic [15:0] word_count;

   always #5 clk = ~clk;

   o_serdes_tx_framer #(
      .WIDTH         (4),
      .FIFO_DEPTH    (4),
      .TRAIN_PATTERN (4'b1010),
      .TRAIN_WORDS   (16)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .enable         (enable),
      .pll_lock       (pll_lock),
      .train_req      (train_req),
      .s_data         (s_data),
      .s_oe           (s_oe),
      .s_valid        (s_valid),
      .s_ready        (s_ready),
      .d_out          (d_out),
      .data_valid_out (data_valid_out),
      .oe_out         (oe_out),
      .state_out      (state_out),
      .train_done     (train_done),
      .underrun       (underrun),
      .word_count     (word_count)
   );

   typedef struct {
      logic        oe;
      logic [3:0]  data;
      int unsigned cyc;
   } exp_t;

   typedef struct {
      logic       s_oe;
      logic [3:0] s_data;
      logic       exp_oe;
      logic [3:0] exp_d;
   } vec_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int unsigned n_cmp   = 0;
   int unsigned n_bad   = 0;
   int unsigned cyc     = 0;
   int unsigned n_under = 0;
   bit          mon_on  = 1'b0;
   bit          chk_lat = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   always @(negedge clk) begin
      if (mon_on) begin
         if (underrun) n_under++;
         if (data_valid_out && state_out == 2'd1) begin
            check("train_word", {oe_out, d_out}, {1'b1, 4'b1010});
         end else if (data_valid_out) begin
            if (exp_q.size() == 0) begin
               check("unexpected_word", data_valid_out, 1'b0);
            end else begin
               mon_e = exp_q.pop_front();
               check("data_word", {oe_out, d_out}, {mon_e.oe, mon_e.data});
               if (chk_lat) check("latency", cyc - mon_e.cyc, 2);
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push_word(input vec_t v);
      int unsigned n;
      n = 0;
      s_oe    = v.s_oe;
      s_data  = v.s_data;
      s_valid = 1'b1;
      while (!s_ready && n < 200) begin
         tick();
         n++;
      end
      if (!s_ready) check("push_timeout", s_ready, 1'b1);
      else exp_q.push_back('{v.exp_oe, v.exp_d, cyc + 1});
      tick();
      s_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int unsigned n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         tick();
         n++;
      end
      check("drain_timeout", exp_q.size(), 0);
   endtask

   task automatic wait_state(input logic [1:0] s, input int unsigned limit);
      int unsigned n;
      n = 0;
      while (state_out != s && n < limit) begin
         tick();
         n++;
      end
      check("wait_state", state_out, s);
   endtask

   initial begin
      vec_t        stream_tbl[3];
      vec_t        bp_tbl[6];
      vec_t        drain_tbl[3];
      vec_t        v;
      int unsigned n;
      int unsigned u0;

      stream_tbl = '{'{1'b0, 4'h3, 1'b0, 4'h3}, '{1'b1, 4'h5, 1'b1, 4'h5}, '{1'b0, 4'h9, 1'b0, 4'h9}};
      bp_tbl     = '{'{1'b1, 4'h1, 1'b1, 4'h1}, '{1'b0, 4'h2, 1'b0, 4'h2}, '{1'b1, 4'h4, 1'b1, 4'h4},
                     '{1'b0, 4'h8, 1'b0, 4'h8}, '{1'b1, 4'h6, 1'b1, 4'h6}, '{1'b0, 4'hC, 1'b0, 4'hC}};
      drain_tbl  = '{'{1'b1, 4'hD, 1'b1, 4'hD}, '{1'b0, 4'hF, 1'b0, 4'hF}, '{1'b1, 4'h0, 1'b1, 4'h0}};

      reset = 1'b0; enable = 1'b0; pll_lock = 1'b0; train_req = 1'b0;
      s_oe = 1'b0; s_data = '0; s_valid = 1'b0;
      tick();
      check("reset_outputs", {d_out, data_valid_out, oe_out, train_done, underrun}, 0);
      check("reset_count", word_count, 0);
      check("reset_state", state_out, 0);
      check("reset_ready", s_ready, 1);

      // Bring-up: lock through synchronizer, then one training burst.
      enable = 1'b1; pll_lock = 1'b1; reset = 1'b1; mon_on = 1'b1;
      n = 0;
      while (state_out != 2'd1 && n < 10) begin
         tick();
         n++;
      end
      check("lock_to_train_cycles", n, 3);
      for (int unsigned i = 0; i < 16; i++) begin
         check("train_state", state_out, 1);
         check("train_done", train_done, (i == 15));
         tick();
      end
      check("run_after_train", state_out, 2);
      check("train_done_cleared", train_done, 0);
      check("first_run_underrun", underrun, 1);

      // Streaming with latency checks.
      chk_lat = 1'b1;
      for (int unsigned i = 0; i < 3; i++) push_word(stream_tbl[i]);
      wait_drain();
      chk_lat = 1'b0;
      check("stream_word_count", word_count, 3);
      u0 = n_under;
      repeat (5) tick();
      check("idle_underruns", n_under - u0, 5);
      check("idle_outputs", {data_valid_out, oe_out, d_out}, 0);

      // Backpressure: six pushes into a retrain burst.
      train_req = 1'b1;
      tick();
      train_req = 1'b0;
      check("retrain_state", state_out, 1);
      for (int unsigned i = 0; i < 4; i++) push_word(bp_tbl[i]);
      check("bp_ready_low", s_ready, 0);
      check("bp_still_training", state_out, 1);
      for (int unsigned i = 4; i < 6; i++) push_word(bp_tbl[i]);
      wait_drain();
      check("bp_word_count", word_count, 9);

      // Retrain with words queued but not yet popped.
      s_oe = 1'b1; s_data = 4'h7; s_valid = 1'b1;
      exp_q.push_back('{1'b1, 4'h7, cyc + 1});
      tick();
      s_oe = 1'b0; s_data = 4'hE; train_req = 1'b1;
      exp_q.push_back('{1'b0, 4'hE, cyc + 1});
      tick();
      s_valid = 1'b0; train_req = 1'b0;
      check("retrain_queued_state", state_out, 1);
      for (int unsigned i = 0; i < 16; i++) begin
         check("retrain_done", train_done, (i == 15));
         tick();
      end
      check("resume_run", state_out, 2);
      check("resume_no_underrun", underrun, 0);
      wait_drain();
      check("retrain_word_count", word_count, 11);

      // Drain: enable drops together with the third push.
      push_word(drain_tbl[0]);
      push_word(drain_tbl[1]);
      enable = 1'b0;
      push_word(drain_tbl[2]);
      check("drain_ready_low", s_ready, 0);
      check("drain_state", state_out, 3);
      u0 = n_under;
      wait_state(2'd0, 20);
      check("drain_no_underrun", n_under - u0, 0);
      check("off_outputs", {data_valid_out, oe_out, d_out}, 0);
      check("drain_all_emitted", exp_q.size(), 0);

      enable = 1'b1;
      tick();
      check("reenable_train", state_out, 1);
      check("count_cleared", word_count, 0);
      wait_state(2'd2, 40);

      // Lock loss with two words accepted; neither may appear.
      pll_lock = 1'b0; s_oe = 1'b0; s_data = 4'h4; s_valid = 1'b1;
      tick();
      s_data = 4'hB;
      tick();
      s_valid = 1'b0;
      n = 0;
      while (state_out != 2'd0 && n < 10) begin
         tick();
         n++;
      end
      check("lockloss_cycles", n + 2, 3);
      check("lockloss_outputs", {data_valid_out, oe_out, d_out}, 0);
      check("lockloss_ready", s_ready, 1);
      repeat (3) tick();
      check("lockloss_stays_off", state_out, 0);
      pll_lock = 1'b1;
      n = 0;
      while (state_out != 2'd1 && n < 10) begin
         tick();
         n++;
      end
      check("relock_cycles", n, 3);
      wait_state(2'd2, 40);
      check("lockloss_flushed", {underrun, data_valid_out}, 2'b10);

      // Saturation of word_count.
      for (int unsigned i = 0; i < 65534; i++) begin
         v = '{i[0], i[3:0], i[0], i[3:0]};
         push_word(v);
      end
      wait_drain();
      check("count_fffe", word_count, 16'hFFFE);
      v = '{1'b1, 4'h5, 1'b1, 4'h5};
      push_word(v);
      wait_drain();
      check("count_ffff", word_count, 16'hFFFF);
      for (int unsigned i = 0; i < 3; i++) push_word(v);
      wait_drain();
      check("count_saturated", word_count, 16'hFFFF);

      // Reset mid-run.
      mon_on = 1'b0;
      reset = 1'b0;
      #1;
      check("midrun_reset_state", state_out, 0);
      check("midrun_reset_count", word_count, 0);
      check("midrun_reset_outputs", {d_out, data_valid_out, oe_out, train_done, underrun}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
